usb_mode_switch_seq: RTL and testbench
======================================

Name: usb_mode_switch_seq

Overview:
- Bus-side sequencer and arbiter for the USB host/slave mux control registers.
- Shares the 1-bit-address mux register port between the CPU bus and an internal mode-switch sequencer.
- On request, the sequencer issues a bus reset through the mux register, waits for the reset pulse to assert and drain, writes the new mode, then reads back the version and mode registers to verify.
- Sits between the bus decoder and the host/slave mux register block, in the busClk domain.

Parameters:
- TIMEOUT_CYCLES, 64, max busClk cycles spent in each reset-wait state before error.
- CNT_W, 7, width of the wait/timeout counter; must hold TIMEOUT_CYCLES.
- VERSION_ID, 8'h22, expected read value of mux register address 1.

Ports:
- busClk  in  1  bus clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- modeReq  in  1  start pulse; sampled only in IDLE.
- modeSel  in  1  requested mode (1=host, 0=slave); latched with modeReq.
- busy  out  1  high while a sequence is running.
- done  out  1  one-cycle pulse when a sequence ends (pass or fail).
- err  out  1  sticky failure flag; cleared by the next accepted modeReq.
- curMode  out  1  tracked current hostMode.
- cpuAddress  in  1  CPU register address.
- cpuDataIn  in  8  CPU write data.
- cpuWriteEn  in  1  CPU write enable.
- cpuStrobe  in  1  CPU access strobe.
- cpuAck  out  1  CPU access accepted this cycle.
- cpuDataOut  out  8  CPU read data.
- muxAddress  out  1  address to the mux register block.
- muxDataOut  out  8  write data to the mux register block.
- muxWriteEn  out  1  write enable to the mux register block.
- muxStrobe  out  1  strobe to the mux register block.
- muxSel  out  1  select to the mux register block.
- muxDataIn  in  8  async read data from the mux register block.
- muxRstIn  in  1  bus-clock-synchronous reset status from the mux register block.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy=0, done=0, err=0, curMode=0.
  - counter=0, latched mode=0.
- CPU arbitration:
  - In IDLE, mux* outputs are a combinational pass-through of cpu*, with muxSel=cpuStrobe.
  - cpuAck = cpuStrobe while in IDLE.
  - cpuDataOut = muxDataIn in IDLE, otherwise 0.
  - Outside IDLE: cpuAck=0 and the CPU stalls; the sequencer owns mux*.
- curMode snoop: on an acked CPU write to address 0:
  - if cpuDataIn[1]=1, curMode<=0 (the mux reset clears hostMode);
  - else curMode<=cpuDataIn[0].
- Sequencer FSM (one bus access per cycle; muxStrobe=muxSel=1 in every access state):
  - IDLE: on modeReq, latch modeSel, clear err, set busy, go to WR_RST.
    - A CPU strobe in the same cycle is still acked.
    - The sequencer's first access is on the next cycle.
  - WR_RST: write address 0, data {6'b0,1'b1,curMode}. Clear counter. Go to WAIT_HI.
  - WAIT_HI: no access; counter increments.
    - muxRstIn=1 -> go to WAIT_LO and clear counter.
    - counter reaches TIMEOUT_CYCLES-1 -> go to FAIL.
  - WAIT_LO: no access; counter increments.
    - muxRstIn=0 -> go to WR_MODE.
    - timeout as in WAIT_HI -> go to FAIL.
  - WR_MODE: write address 0, data {7'b0,latched mode}. Go to RD_VER.
  - RD_VER: read address 1.
    - muxDataIn==VERSION_ID -> go to RD_MODE; else -> go to FAIL.
  - RD_MODE: read address 0.
    - muxDataIn[0]==latched mode -> curMode<=latched mode, go to FIN; else -> go to FAIL.
  - FIN: done=1 for one cycle, busy<=0, go to IDLE.
  - FAIL: done=1 and err<=1 for this cycle, curMode<=0, busy<=0, go to IDLE.
- Boundary rules:
  - modeReq while busy: ignored, not queued.
  - Counter saturates; it never wraps.
  - Async rst mid-sequence: return to IDLE immediately, all outputs to reset values, no done pulse.
  - muxRstIn asserting outside a sequence does not change FSM state.
- Latency (no CPU contention, reset-drain length D cycles):
  - done occurs D+8 cycles after the modeReq cycle, give or take the mux reset-assert delay.

Decomposition:
- Shared package usb_mode_pkg:
  - FSM state enum (IDLE, WR_RST, WAIT_HI, WAIT_LO, WR_MODE, RD_VER, RD_MODE, FIN, FAIL).
  - Register address constants MUX_ADDR_CTRL=0 and MUX_ADDR_VER=1.
  - Control bit indices CTRL_MODE_BIT=0 and CTRL_RST_BIT=1.
- Sub-module usb_mode_wait_cnt: saturating counter with clear, enable and timeout output.

Test Plan:
- Switch to host with a reset model (muxRstIn high 2 cycles after the reset write, for 6 cycles), VERSION 8'h22 and mode readback 1 -> write data 8'h02 then 8'h01, done pulse, err=0, curMode=1, busy low after FIN.
- Same as above but version reads 8'h21 -> done pulse with err=1, curMode=0, no RD_MODE access.
- muxRstIn stuck at 0 -> FAIL after exactly 64 cycles in WAIT_HI, err=1.
- CPU strobe while busy -> cpuAck=0 until IDLE; CPU strobe in the same cycle as modeReq -> acked, sequencer write follows next cycle.
- CPU write 8'h01 to address 0 in IDLE -> curMode=1; then write 8'h03 -> curMode=0.
- Assert rst during WAIT_LO -> immediately IDLE, busy=0, done=0, err=0; a subsequent modeReq runs normally.

Source files
------------

// File: rtl/usb_mode_pkg.sv
// Shared types and register map for the USB host/slave mode-switch sequencer.
// Covers the mux control/version register addresses and the control bit layout.
package usb_mode_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_RST,
        WAIT_HI,
        WAIT_LO,
        WR_MODE,
        RD_VER,
        RD_MODE,
        FIN,
        FAIL
    } seqState_t;

    localparam logic MUX_ADDR_CTRL = 1'b0;
    localparam logic MUX_ADDR_VER  = 1'b1;

    localparam int CTRL_MODE_BIT = 0;
    localparam int CTRL_RST_BIT  = 1;

    // Control register image with only the reset and mode bits populated.
    function automatic logic [7:0] ctrlWord(input logic rstBit, input logic mode);
        logic [7:0] w;
        w = '0;
        w[CTRL_RST_BIT]  = rstBit;
        w[CTRL_MODE_BIT] = mode;
        return w;
    endfunction

endpackage

// File: rtl/usb_mode_wait_cnt.sv
// Saturating wait counter for the reset-wait states.
// The timeout flag is raised once the count reaches TIMEOUT_CYCLES-1.
module usb_mode_wait_cnt #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic busClk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Holds at LAST so a stalled wait state can never wrap back below the limit.
    always_ff @(posedge busClk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/usb_mode_switch_seq.sv
// Arbitrates the mux register port between the CPU and a mode-switch sequencer
// that resets the mux block, writes the new mode and verifies it by readback.
module usb_mode_switch_seq
    import usb_mode_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         CNT_W          = 7,
    parameter logic [7:0] VERSION_ID     = 8'h22
) (
    input  logic       busClk,
    input  logic       rst,
    input  logic       modeReq,
    input  logic       modeSel,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       curMode,
    input  logic       cpuAddress,
    input  logic [7:0] cpuDataIn,
    input  logic       cpuWriteEn,
    input  logic       cpuStrobe,
    output logic       cpuAck,
    output logic [7:0] cpuDataOut,
    output logic       muxAddress,
    output logic [7:0] muxDataOut,
    output logic       muxWriteEn,
    output logic       muxStrobe,
    output logic       muxSel,
    input  logic [7:0] muxDataIn,
    input  logic       muxRstIn
);

    seqState_t state;
    logic      latMode;
    logic      isIdle;
    logic      cpuCtrlWr;
    logic      cntClr;
    logic      cntEn;
    logic      timeout;

    assign isIdle     = (state == IDLE);
    assign cpuAck     = isIdle & cpuStrobe;
    assign cpuDataOut = isIdle ? muxDataIn : 8'h00;
    assign cpuCtrlWr  = cpuAck & cpuWriteEn & (cpuAddress == MUX_ADDR_CTRL);

    assign cntClr = (state == WR_RST) | ((state == WAIT_HI) & muxRstIn);
    assign cntEn  = (state == WAIT_HI) | (state == WAIT_LO);

    usb_mode_wait_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) uWaitCnt (
        .busClk (busClk),
        .rst    (rst),
        .clr    (cntClr),
        .en     (cntEn),
        .timeout(timeout)
    );

    // CPU passes straight through in IDLE; every other state owns the port.
    always_comb begin
        muxAddress = cpuAddress;
        muxDataOut = cpuDataIn;
        muxWriteEn = cpuWriteEn;
        muxStrobe  = cpuStrobe;
        muxSel     = cpuStrobe;
        if (!isIdle) begin
            muxAddress = MUX_ADDR_CTRL;
            muxDataOut = 8'h00;
            muxWriteEn = 1'b0;
            muxStrobe  = 1'b0;
            muxSel     = 1'b0;
        end
        case (state)
            WR_RST: begin
                muxDataOut = ctrlWord(1'b1, curMode);
                muxWriteEn = 1'b1;
                muxStrobe  = 1'b1;
                muxSel     = 1'b1;
            end
            WR_MODE: begin
                muxDataOut = ctrlWord(1'b0, latMode);
                muxWriteEn = 1'b1;
                muxStrobe  = 1'b1;
                muxSel     = 1'b1;
            end
            RD_VER: begin
                muxAddress = MUX_ADDR_VER;
                muxStrobe  = 1'b1;
                muxSel     = 1'b1;
            end
            RD_MODE: begin
                muxStrobe = 1'b1;
                muxSel    = 1'b1;
            end
            default: ;
        endcase
    end

    // done/err are set on entry to FIN/FAIL so they line up with the end state.
    always_ff @(posedge busClk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            curMode <= 1'b0;
            latMode <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpuCtrlWr) begin
                        curMode <= cpuDataIn[CTRL_RST_BIT] ? 1'b0 : cpuDataIn[CTRL_MODE_BIT];
                    end
                    if (modeReq) begin
                        latMode <= modeSel;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= WR_RST;
                    end
                end
                WR_RST: state <= WAIT_HI;
                WAIT_HI: begin
                    if (muxRstIn) begin
                        state <= WAIT_LO;
                    end else if (timeout) begin
                        state <= FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!muxRstIn) begin
                        state <= WR_MODE;
                    end else if (timeout) begin
                        state <= FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                WR_MODE: state <= RD_VER;
                RD_VER: begin
                    if (muxDataIn == VERSION_ID) begin
                        state <= RD_MODE;
                    end else begin
                        state <= FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                RD_MODE: begin
                    if (muxDataIn[CTRL_MODE_BIT] == latMode) begin
                        curMode <= latMode;
                        state   <= FIN;
                        done    <= 1'b1;
                    end else begin
                        state <= FAIL;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAIL: begin
                    err     <= 1'b1;
                    curMode <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_mode_switch_seq.sv
// Directed bench for usb_mode_switch_seq with a small mux register block model
// (control register, version register, delayed reset pulse).
module tb_usb_mode_switch_seq;

    logic       busClk;
    logic       rst;
    logic       modeReq, modeSel;
    logic       busy, done, err, curMode;
    logic       cpuAddress;
    logic [7:0] cpuDataIn;
    logic       cpuWriteEn, cpuStrobe, cpuAck;
    logic [7:0] cpuDataOut;
    logic       muxAddress;
    logic [7:0] muxDataOut;
    logic       muxWriteEn, muxStrobe, muxSel;
    logic [7:0] muxDataIn;
    logic       muxRstIn;

    int vecCount  = 0;
    int missCount = 0;

    // mux register block model
    logic [7:0] tbVersion   = 8'h22;
    logic       rstModelEn  = 1'b1;
    logic       tbForceRst  = 1'b0;
    logic [3:0] rstPh       = 4'd0;
    logic [7:0] ctrlReg     = 8'h00;
    logic [7:0] wrLog[$];
    logic       rdLog[$];

    usb_mode_switch_seq dut (
        .busClk(busClk), .rst(rst), .modeReq(modeReq), .modeSel(modeSel),
        .busy(busy), .done(done), .err(err), .curMode(curMode),
        .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn), .cpuWriteEn(cpuWriteEn),
        .cpuStrobe(cpuStrobe), .cpuAck(cpuAck), .cpuDataOut(cpuDataOut),
        .muxAddress(muxAddress), .muxDataOut(muxDataOut), .muxWriteEn(muxWriteEn),
        .muxStrobe(muxStrobe), .muxSel(muxSel), .muxDataIn(muxDataIn), .muxRstIn(muxRstIn)
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    // Reset pulse: high from 2 cycles after the reset write, for 6 cycles.
    assign muxRstIn  = tbForceRst | (rstModelEn & (rstPh >= 4'd2) & (rstPh < 4'd8));
    assign muxDataIn = muxAddress ? tbVersion : ctrlReg;

    always @(posedge busClk) begin
        if (rstPh != 4'd0 && rstPh < 4'd8) rstPh <= rstPh + 4'd1;
        if (muxStrobe && muxSel && muxWriteEn && !muxAddress) begin
            wrLog.push_back(muxDataOut);
            ctrlReg <= muxDataOut & 8'h01;
            if (muxDataOut[1]) rstPh <= 4'd1;
        end
        if (muxStrobe && muxSel && !muxWriteEn) rdLog.push_back(muxAddress);
    end

    task automatic startSeq(input logic sel);
        @(negedge busClk);
        modeReq = 1'b1;
        modeSel = sel;
        @(negedge busClk);
        modeReq = 1'b0;
    endtask

    // Called at the negedge of the cycle after modeReq (cycle 1); returns done's cycle.
    task automatic waitDone(inout int cyc);
        while (!done && cyc < 200) begin
            @(negedge busClk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        vecCount++;
        if ({busy, done, err, curMode} !== 4'b0000) begin
            missCount++;
            $display("FAIL reset_outputs: got %b want 0000", {busy, done, err, curMode});
        end
        vecCount++;
        if (cpuAck !== 1'b0 || muxStrobe !== 1'b0) begin
            missCount++;
            $display("FAIL reset_port: got ack=%b strobe=%b want 0 0", cpuAck, muxStrobe);
        end
    endtask

    task automatic test_cpu_snoop;
        @(negedge busClk);
        cpuStrobe = 1'b1; cpuWriteEn = 1'b1; cpuAddress = 1'b0; cpuDataIn = 8'h01;
        #1;
        vecCount++;
        if ({cpuAck, muxSel, muxWriteEn, muxDataOut} !== {3'b111, 8'h01}) begin
            missCount++;
            $display("FAIL cpu_passthru: got %b_%h want 111_01",
                     {cpuAck, muxSel, muxWriteEn}, muxDataOut);
        end
        @(negedge busClk);
        cpuStrobe = 1'b0; cpuWriteEn = 1'b0;
        #1;
        vecCount++;
        if (curMode !== 1'b1) begin
            missCount++;
            $display("FAIL snoop_wr01: got %b want 1", curMode);
        end
        @(negedge busClk);
        cpuStrobe = 1'b1; cpuWriteEn = 1'b1; cpuDataIn = 8'h03;
        @(negedge busClk);
        cpuStrobe = 1'b0; cpuWriteEn = 1'b0;
        #1;
        vecCount++;
        if (curMode !== 1'b0) begin
            missCount++;
            $display("FAIL snoop_wr03: got %b want 0", curMode);
        end
        @(negedge busClk);
        cpuStrobe = 1'b1; cpuAddress = 1'b1;
        #1;
        vecCount++;
        if (cpuDataOut !== 8'h22 || cpuAck !== 1'b1) begin
            missCount++;
            $display("FAIL cpu_read_ver: got %h ack=%b want 22 ack=1", cpuDataOut, cpuAck);
        end
        @(negedge busClk);
        cpuStrobe = 1'b0; cpuAddress = 1'b0;
        repeat (8) @(negedge busClk);
    endtask

    task automatic test_switch_host;
        int cyc;
        logic [7:0] w0, w1;
        wrLog.delete(); rdLog.delete();
        startSeq(1'b1);
        vecCount++;
        if (busy !== 1'b1) begin
            missCount++;
            $display("FAIL host_busy: got %b want 1", busy);
        end
        cyc = 1;
        waitDone(cyc);
        // WR_RST c1, WAIT_HI c2-3, WAIT_LO c4-9, WR_MODE c10, RD_VER c11, RD_MODE c12, FIN c13
        vecCount++;
        if (cyc !== 13) begin
            missCount++;
            $display("FAIL host_latency: got %0d want 13", cyc);
        end
        vecCount++;
        if (err !== 1'b0 || curMode !== 1'b1) begin
            missCount++;
            $display("FAIL host_result: got err=%b mode=%b want err=0 mode=1", err, curMode);
        end
        w0 = (wrLog.size() > 0) ? wrLog[0] : 8'hxx;
        w1 = (wrLog.size() > 1) ? wrLog[1] : 8'hxx;
        vecCount++;
        if (wrLog.size() !== 2 || {w0, w1} !== 16'h0201) begin
            missCount++;
            $display("FAIL host_writes: got n=%0d %h %h want 02 01", wrLog.size(), w0, w1);
        end
        vecCount++;
        if (rdLog.size() !== 2 || {rdLog[0], rdLog[1]} !== 2'b10) begin
            missCount++;
            $display("FAIL host_reads: got n=%0d want addr 1 then 0", rdLog.size());
        end
        @(negedge busClk);
        vecCount++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            missCount++;
            $display("FAIL host_end: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_bad_version;
        int cyc;
        logic [7:0] w0, w1;
        tbVersion = 8'h21;
        wrLog.delete(); rdLog.delete();
        startSeq(1'b1);
        cyc = 1;
        waitDone(cyc);
        vecCount++;
        if (cyc !== 12 || err !== 1'b1) begin
            missCount++;
            $display("FAIL badver_done: got cyc=%0d err=%b want 12 1", cyc, err);
        end
        w0 = (wrLog.size() > 0) ? wrLog[0] : 8'hxx;
        w1 = (wrLog.size() > 1) ? wrLog[1] : 8'hxx;
        vecCount++;
        if (wrLog.size() !== 2 || {w0, w1} !== 16'h0301) begin
            missCount++;
            $display("FAIL badver_writes: got n=%0d %h %h want 03 01", wrLog.size(), w0, w1);
        end
        vecCount++;
        if (rdLog.size() !== 1) begin
            missCount++;
            $display("FAIL badver_no_rdmode: got %0d reads want 1", rdLog.size());
        end
        @(negedge busClk);
        vecCount++;
        if ({busy, err, curMode} !== 3'b010) begin
            missCount++;
            $display("FAIL badver_end: got busy,err,mode=%b want 010", {busy, err, curMode});
        end
        tbVersion = 8'h22;
    endtask

    task automatic test_timeout;
        int cyc;
        rstModelEn = 1'b0;
        startSeq(1'b1);
        vecCount++;
        if (err !== 1'b0) begin
            missCount++;
            $display("FAIL err_clear_on_req: got %b want 0", err);
        end
        cyc = 1;
        waitDone(cyc);
        // WAIT_HI occupies cycles 2..65, FAIL on 66
        vecCount++;
        if (cyc !== 66 || err !== 1'b1) begin
            missCount++;
            $display("FAIL timeout: got cyc=%0d err=%b want 66 1", cyc, err);
        end
        @(negedge busClk);
        rstModelEn = 1'b1;
    endtask

    task automatic test_cpu_stall;
        int cyc;
        int ackSeen;
        @(negedge busClk);
        modeReq = 1'b1; modeSel = 1'b1;
        cpuStrobe = 1'b1; cpuWriteEn = 1'b0; cpuAddress = 1'b1;
        #1;
        vecCount++;
        if (cpuAck !== 1'b1 || cpuDataOut !== 8'h22) begin
            missCount++;
            $display("FAIL same_cycle_ack: got ack=%b data=%h want 1 22", cpuAck, cpuDataOut);
        end
        @(negedge busClk);
        modeReq = 1'b0;
        #1;
        vecCount++;
        if ({cpuAck, muxWriteEn, muxAddress, muxDataOut, cpuDataOut} !== {3'b010, 8'h02, 8'h00}) begin
            missCount++;
            $display("FAIL seq_next_cycle: got ack=%b we=%b a=%b d=%h cpu=%h want 0 1 0 02 00",
                     cpuAck, muxWriteEn, muxAddress, muxDataOut, cpuDataOut);
        end
        cyc = 1;
        ackSeen = 0;
        while (busy && cyc < 200) begin
            if (cpuAck) ackSeen++;
            @(negedge busClk);
            cyc++;
        end
        #1;
        vecCount++;
        if (ackSeen !== 0 || cpuAck !== 1'b1) begin
            missCount++;
            $display("FAIL stall_ack: got %0d busy acks, idle ack=%b want 0 1", ackSeen, cpuAck);
        end
        cpuStrobe = 1'b0; cpuAddress = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int busyAfter;
        wrLog.delete();
        startSeq(1'b0);
        repeat (3) @(negedge busClk);
        modeReq = 1'b1; modeSel = 1'b1;
        @(negedge busClk);
        modeReq = 1'b0;
        cyc = 5;
        waitDone(cyc);
        vecCount++;
        if (cyc !== 13 || err !== 1'b0 || curMode !== 1'b0) begin
            missCount++;
            $display("FAIL req_while_busy: got cyc=%0d err=%b mode=%b want 13 0 0", cyc, err, curMode);
        end
        busyAfter = 0;
        repeat (4) begin
            @(negedge busClk);
            if (busy) busyAfter++;
        end
        vecCount++;
        if (busyAfter !== 0 || wrLog.size() !== 2) begin
            missCount++;
            $display("FAIL not_queued: got busy=%0d writes=%0d want 0 2", busyAfter, wrLog.size());
        end
    endtask

    task automatic test_rst_idle_noise;
        int busySeen;
        busySeen = 0;
        @(negedge busClk);
        tbForceRst = 1'b1;
        cpuStrobe = 1'b1; cpuAddress = 1'b1;
        repeat (4) begin
            @(negedge busClk);
            if (busy || done || !cpuAck) busySeen++;
        end
        tbForceRst = 1'b0;
        cpuStrobe = 1'b0; cpuAddress = 1'b0;
        vecCount++;
        if (busySeen !== 0) begin
            missCount++;
            $display("FAIL idle_rst_noise: got %0d disturbed cycles want 0", busySeen);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        int doneSeen;
        @(negedge busClk);
        cpuStrobe = 1'b1; cpuWriteEn = 1'b1; cpuAddress = 1'b0; cpuDataIn = 8'h01;
        @(negedge busClk);
        cpuStrobe = 1'b0; cpuWriteEn = 1'b0;
        repeat (8) @(negedge busClk);
        startSeq(1'b0);
        repeat (4) @(negedge busClk);
        rst = 1'b1;
        #1;
        vecCount++;
        if ({busy, done, err, curMode} !== 4'b0000) begin
            missCount++;
            $display("FAIL async_rst: got busy,done,err,mode=%b want 0000", {busy, done, err, curMode});
        end
        doneSeen = 0;
        repeat (3) begin
            @(negedge busClk);
            if (done || busy) doneSeen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge busClk);
            if (done || busy) doneSeen++;
        end
        vecCount++;
        if (doneSeen !== 0) begin
            missCount++;
            $display("FAIL rst_no_done: got %0d active cycles want 0", doneSeen);
        end
        startSeq(1'b1);
        cyc = 1;
        waitDone(cyc);
        vecCount++;
        if (cyc !== 13 || err !== 1'b0 || curMode !== 1'b1) begin
            missCount++;
            $display("FAIL after_rst_run: got cyc=%0d err=%b mode=%b want 13 0 1", cyc, err, curMode);
        end
    endtask

    initial begin
        rst = 1'b1;
        modeReq = 1'b0; modeSel = 1'b0;
        cpuAddress = 1'b0; cpuDataIn = 8'h00; cpuWriteEn = 1'b0; cpuStrobe = 1'b0;
        repeat (2) @(negedge busClk);
        test_reset;
        rst = 1'b0;
        test_cpu_snoop;
        test_switch_host;
        test_bad_version;
        test_timeout;
        test_cpu_stall;
        test_back_to_back;
        test_rst_idle_noise;
        test_async_reset;
        repeat (2) @(negedge busClk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
